wr_port_arbiter: RTL
====================

// Module: wr_port_arbiter
// PURPOSE
//  Shares the async-FIFO write port (wclk domain) between NUM_REQ valid/ready requesters.
//  Uses round-robin grant with bounded bursts and space-aware throttling from wfull/wr_level.
//  Drives wdata/write_enable/afull_value/sw_rst into the FIFO write side.
//  Sequences the sw_rst pulse after hw reset and on flush requests.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  DATA_W         32  write data width
//  DEPTH          32  FIFO depth, compared against wr_level
//  MAX_BURST      4   max beats per grant before re-arbitration (1..15)
//  SW_RST_CYCLES  3   sw_rst pulse length in wclk cycles (1..15)
//  AFULL_RST      5'd28  afull_value after reset
// PORTS
//  wclk             in   1                 write clock; single clock
//  hw_rst_n         in   1                 async active-low reset
//  req_valid        in   NUM_REQ           per-requester beat valid
//  req_data         in   NUM_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//  req_ready        out  NUM_REQ           beat accepted when valid&ready (combinational)
//  flush_req        in   1                 one-cycle pulse: drain grant, pulse sw_rst
//  cfg_afull_wr     in   1                 load cfg_afull_value into afull_value
//  cfg_afull_value  in   5                 new almost-full threshold
//  wfull            in   1                 FIFO full
//  wr_almost_ful    in   1                 FIFO almost full (status only; no gating)
//  overflow         in   1                 FIFO overflow flag
//  wr_level         in   6                 FIFO write-side level
//  wdata            out  DATA_W            registered write data
//  write_enable     out  1                 registered write strobe
//  afull_value      out  5                 registered threshold
//  sw_rst           out  1                 registered soft reset to FIFO
//  grant_id         out  $clog2(NUM_REQ)   current/last owner
//  busy             out  1                 state != IDLE
//  err_overflow     out  1                 sticky overflow seen
// BEHAVIOUR
//  Reset values (hw_rst_n=0, async):
//   - wdata=0, write_enable=0, sw_rst=0, afull_value=AFULL_RST
//   - grant_id=0, rr_ptr=0, beat_cnt=0, err_overflow=0
//   - state=INIT; the first cycle after release asserts sw_rst
//  States:
//   - INIT:  sw_rst=1 for SW_RST_CYCLES cycles, then IDLE.
//   - IDLE:  flush_req -> FLUSH. Else, if any req_valid: winner = first valid at/after rr_ptr
//            (mod NUM_REQ); grant_id<=winner; beat_cnt<=0; -> GRANT. No beat accepted in IDLE.
//   - GRANT: see gating below.
//   - FLUSH: sw_rst=1 for SW_RST_CYCLES cycles; req_ready=0; err_overflow cleared on exit;
//            -> IDLE.
//  GRANT gating:
//   - space = !wfull && ({1'b0,wr_level} + write_enable) < DEPTH
//     (7-bit compare; accounts for the write in flight).
//   - req_ready[i] = (state==GRANT) && (i==grant_id) && space && !flush_req.
//   - Accept: wdata<=req_data[owner], write_enable<=1 next cycle (latency 1);
//     otherwise write_enable<=0.
//  GRANT exit (to IDLE, rr_ptr<=grant_id+1 mod NUM_REQ) when any of:
//   - owner valid low;
//   - beat_cnt reaches MAX_BURST after an accept;
//   - flush_req (-> FLUSH directly).
//   No space holds GRANT without advancing beat_cnt.
//  Flush/INIT beats: req_ready=0 throughout; an in-flight write_enable still completes
//   the cycle before sw_rst rises.
//  Simultaneous:
//   - flush_req in INIT is ignored.
//   - cfg_afull_wr is honoured in any state; afull_value updates next cycle.
//  Overflow: err_overflow<=1 on overflow=1 in any state except INIT/FLUSH.
//  Mid-operation reset: everything returns to reset values immediately; no partial write.
// TESTING
//  - Reset release: sw_rst high exactly 3 cycles, afull_value=28, then busy=0.
//  - RR fairness: req_valid=4'b1111 continuous, wr_level=0 -> grants 0,1,2,3,0;
//    4 beats each (MAX_BURST=4); 1 IDLE cycle between grants.
//  - Backpressure: wr_level=31 with write_enable=1 -> req_ready=0 next cycle;
//    wfull=1 -> no write_enable; resumes when wr_level=30, wfull=0.
//  - Early release: req1 valid for 2 beats only -> 2 writes, grant moves to 2.
//  - Flush mid-burst: flush_req on 2nd beat -> req_ready=0 that cycle, sw_rst 3 cycles,
//    err_overflow cleared, IDLE.
//  - Config/overflow: cfg_afull_wr with 5'd20 -> afull_value=20 next cycle;
//    overflow pulse -> err_overflow stays 1 until flush.

Source files
------------

// File: rtl/wr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wr_port_arbiter
// Purpose  : Shares the write port of an async FIFO (wclk domain) between
//            NUM_REQ valid/ready requesters. Round-robin grants with bounded
//            bursts, throttled by FIFO space (wfull / wr_level), and sequences
//            the FIFO soft reset after hardware reset and on flush requests.
// Ports    : wclk, hw_rst_n       - clock, async active-low reset
//            req_valid/req_data   - requester beats (data packed per requester)
//            req_ready            - combinational beat accept per requester
//            flush_req            - pulse: drop grant and pulse sw_rst
//            cfg_afull_wr/value   - load new almost-full threshold
//            wfull, wr_almost_ful, overflow, wr_level - FIFO write-side status
//            wdata, write_enable, afull_value, sw_rst - FIFO write-side drive
//            grant_id, busy, err_overflow           - arbiter status
// Revision : 1.0 - initial release
// ============================================================================
module wr_port_arbiter #(
  parameter int         NUM_REQ       = 4,
  parameter int         DATA_W        = 32,
  parameter int         DEPTH         = 32,
  parameter int         MAX_BURST     = 4,
  parameter int         SW_RST_CYCLES = 3,
  parameter logic [4:0] AFULL_RST     = 5'd28
) (
  input  logic                       wclk,
  input  logic                       hw_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       flush_req,
  input  logic                       cfg_afull_wr,
  input  logic [4:0]                 cfg_afull_value,
  input  logic                       wfull,
  input  logic                       wr_almost_ful,
  input  logic                       overflow,
  input  logic [5:0]                 wr_level,
  output logic [DATA_W-1:0]          wdata,
  output logic                       write_enable,
  output logic [4:0]                 afull_value,
  output logic                       sw_rst,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_overflow
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [3:0]    c_burst_last = 4'(MAX_BURST - 1);
  localparam logic [3:0]    c_seq_last   = 4'(SW_RST_CYCLES - 1);
  localparam logic [6:0]    c_depth      = 7'(DEPTH);
  localparam logic [ID_W:0] c_num_req    = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W:0] c_id_one     = (ID_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GRANT = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [3:0]         r_beat_cnt;
  logic [3:0]         r_seq_cnt;

  logic [DATA_W-1:0]  w_req_data [NUM_REQ];
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_cand;
  logic               w_found;
  logic [6:0]         w_level_sum;
  logic               w_space;
  logic               w_accept;
  logic               w_grant_load;
  logic               w_grant_exit;
  logic               w_unused;

  // Almost-full is informational only; it never gates writes.
  assign w_unused = wr_almost_ful;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_data[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Requester index arithmetic modulo NUM_REQ (also valid for non power-of-2).
  function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W:0] sum);
    logic [ID_W:0] t;
    t = (sum >= c_num_req) ? (sum - c_num_req) : sum;
    return t[ID_W-1:0];
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_cand   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = wrap_id({1'b0, r_rr_ptr} + k[ID_W:0]);
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // The write launched last cycle is not yet visible in wr_level, so count it.
  assign w_level_sum = {1'b0, wr_level} + {6'd0, write_enable};
  assign w_space     = !wfull && (w_level_sum < c_depth);

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge wclk or negedge hw_rst_n) begin
    if (!hw_rst_n) r_state <= ST_INIT;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    w_accept     = 1'b0;
    w_grant_load = 1'b0;
    w_grant_exit = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_seq_cnt == c_seq_last) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush_req) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_found) begin
          w_grant_load = 1'b1;
          w_state_nxt  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_space && !flush_req) req_ready[grant_id] = 1'b1;
        w_accept = req_ready[grant_id] && req_valid[grant_id];
        if (flush_req) begin
          w_grant_exit = 1'b1;
          w_state_nxt  = ST_FLUSH;
        end else if (!req_valid[grant_id]) begin
          w_grant_exit = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (w_accept && (r_beat_cnt == c_burst_last)) begin
          w_grant_exit = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (r_seq_cnt == c_seq_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge wclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      wdata        <= '0;
      write_enable <= 1'b0;
      sw_rst       <= 1'b0;
      afull_value  <= AFULL_RST;
      grant_id     <= '0;
      r_rr_ptr     <= '0;
      r_beat_cnt   <= '0;
      r_seq_cnt    <= '0;
      err_overflow <= 1'b0;
    end else begin
      write_enable <= w_accept;
      if (w_accept) wdata <= w_req_data[grant_id];

      // sw_rst follows the state by one cycle, so a write accepted just
      // before a flush still lands ahead of the soft reset.
      sw_rst <= (r_state == ST_INIT) || (r_state == ST_FLUSH);

      if (cfg_afull_wr) afull_value <= cfg_afull_value;

      if (w_grant_load) begin
        grant_id   <= w_winner;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
      end

      if (w_grant_exit) r_rr_ptr <= wrap_id({1'b0, grant_id} + c_id_one);

      if (((r_state == ST_INIT) || (r_state == ST_FLUSH)) && (w_state_nxt == r_state))
        r_seq_cnt <= r_seq_cnt + 4'd1;
      else
        r_seq_cnt <= '0;

      if ((r_state == ST_FLUSH) && (w_state_nxt == ST_IDLE))
        err_overflow <= 1'b0;
      else if (overflow && (r_state != ST_INIT) && (r_state != ST_FLUSH))
        err_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
